// File: rtl/spi_regfile_pkg.sv
// Shared types and sizing helpers for the SPI register-file peripheral.
// Optional feature macro used by the top level: SPI_READBACK_EN.
package spi_regfile_pkg;

  // Frame-tracking FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    FULL   = 3'd3,
    COMMIT = 3'd4
  } state_t;

  // Bits in one frame: rw flag, address field, data field.
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Bit counter width; it must reach frame_len+1 so overruns stay visible.
  function automatic int cnt_width(input int flen);
    return $clog2(flen + 2);
  endfunction

endpackage

// File: rtl/spi_regfile_periph_if.sv
// Pin-level SPI bundle between the chip pads and the register-file peripheral.
// Protocol: mode 0. ncs_in low frames a transfer; copi_in is sampled on sclk_in
// rising edges and cipo_out changes on falling edges. There is no back-pressure:
// every sclk rising edge while ncs_in is low carries exactly one bit, and the
// peripheral drives cipo_out onto the pad only while cipo_oe is high.
interface spi_regfile_periph_if;
  logic ncs_in;
  logic copi_in;
  logic sclk_in;
  logic cipo_out;
  logic cipo_oe;

  modport master (output ncs_in, output copi_in, output sclk_in,
                  input cipo_out, input cipo_oe);
  modport slave  (input ncs_in, input copi_in, input sclk_in,
                  output cipo_out, output cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a single
// history flop that yields one-clk rise/fall pulses on the synced level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus edge-detect history; resets to the pin's idle level
  // so leaving reset never fabricates an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral holding NUM_REGS x DATA_W configuration registers.
// Frame: rw bit (1 = write), ADDR_W address bits, DATA_W data bits, MSB first.
// Writes land when ncs rises after an exactly-sized frame with an in-range
// address; malformed frames pulse frame_err instead.
// Optional feature macro: SPI_READBACK_EN (read frames return reg[addr] on cipo).
module spi_regfile_periph
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_periph_if.slave        spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err,
  output state_t                     dbg_state
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int HDR_LEN   = 1 + ADDR_W;
  localparam int CNT_W     = cnt_width(FRAME_LEN);

  localparam logic [CNT_W-1:0] CNT_HDR_LAST   = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME      = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_SAT        = CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0]  NUM_REGS_CMP   = (ADDR_W + 1)'(NUM_REGS);

  // Synced pin views.
  logic ncs_level, ncs_rise, ncs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_in(spi.ncs_in),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(spi.sclk_in),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_in(spi.copi_in),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  // Entry into ADDR is level-based, and copi is only ever sampled as a level.
  logic unused_edges;
  assign unused_edges = ^{ncs_fall, copi_rise, copi_fall, sclk_level};

  // FSM and frame datapath signals.
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic                   bit_in;
  logic                   shift_en, cnt_en, frame_clr;
  logic                   commit_wr, commit_err;
  logic                   frame_rw, frame_ok, addr_ok;
  logic [ADDR_W-1:0]      frame_addr;
  logic [DATA_W-1:0]      frame_data;
  logic [NUM_REGS-1:0]    wr_sel;
  logic [NUM_REGS-1:0]    wr_strobe_q;
  logic                   frame_err_q;

  // A bit is only taken while the chip is selected; sclk with ncs high is noise.
  assign bit_in  = sclk_rise & ~ncs_level;
  assign shift_d = {shift_q[FRAME_LEN-2:0], copi_level};

  assign frame_rw   = shift_q[FRAME_LEN-1];
  assign frame_addr = shift_q[DATA_W +: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];
  assign frame_ok   = (cnt_q == CNT_FRAME);
  assign addr_ok    = ({1'b0, frame_addr} < NUM_REGS_CMP);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: ncs rise ends the frame from any active state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ncs_rise)        state_d = COMMIT;
        else if (!ncs_level) state_d = ADDR;
      end
      ADDR: begin
        if (ncs_rise)                              state_d = COMMIT;
        else if (bit_in && cnt_q == CNT_HDR_LAST)  state_d = DATA;
      end
      DATA: begin
        if (ncs_rise)                                state_d = COMMIT;
        else if (bit_in && cnt_q == CNT_FRAME_LAST)  state_d = FULL;
      end
      FULL: begin
        if (ncs_rise) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: shift/count enables and the commit verdict.
  always_comb begin
    shift_en   = 1'b0;
    cnt_en     = 1'b0;
    frame_clr  = 1'b0;
    commit_wr  = 1'b0;
    commit_err = 1'b0;
    case (state_q)
      ADDR, DATA: begin
        shift_en = bit_in;
        cnt_en   = bit_in;
      end
      FULL: begin
        cnt_en = bit_in && (cnt_q != CNT_SAT);
      end
      COMMIT: begin
        frame_clr  = 1'b1;
        commit_wr  = frame_ok && frame_rw && addr_ok;
        commit_err = !frame_ok || (frame_rw && !addr_ok);
      end
      default: ;
    endcase
  end

  // Bit counter and frame shift register; cleared as each frame is retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (frame_clr) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      if (cnt_en)   cnt_q   <= cnt_q + 1'b1;
      if (shift_en) shift_q <= shift_d;
    end
  end

  // Register bank: one DATA_W register per address.
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    logic [DATA_W-1:0] reg_q;

    assign wr_sel[k] = commit_wr && (frame_addr == ADDR_W'(k));

    // Capture data on the commit cycle of a write addressed here.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         reg_q <= '0;
      else if (wr_sel[k]) reg_q <= frame_data;
    end

    assign regs_out[k*DATA_W +: DATA_W] = reg_q;
  end

  // Strobe and error pulses, registered so they coincide with the new regs_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_strobe_q <= wr_sel;
      frame_err_q <= commit_err;
    end
  end

  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(HDR_LEN);

  logic [DATA_W-1:0] shift_out_q;
  logic [DATA_W-1:0] rd_val;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rw;
  logic              load_out;
  logic              shift_out_en;

  // The header is complete in shift_d on the ADDR->DATA transition cycle.
  assign rd_rw    = shift_d[ADDR_W];
  assign rd_addr  = shift_d[ADDR_W-1:0];
  assign load_out = (state_q == ADDR) && (state_d == DATA);
  // The first falling edge in DATA precedes the first data rise, so the MSB must
  // be held through it; shift only after at least one data bit was sampled.
  assign shift_out_en = sclk_fall && !ncs_level && (state_q == DATA) && (cnt_q != CNT_HDR);

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) rd_val = regs_out[k*DATA_W +: DATA_W];
    end
  end

  // Read-back shifter: loaded once per read frame, so a commit cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            shift_out_q <= '0;
    else if (frame_clr)    shift_out_q <= '0;
    else if (load_out)     shift_out_q <= rd_rw ? '0 : rd_val;
    else if (shift_out_en) shift_out_q <= shift_out_q << 1;
  end

  assign spi.cipo_out = shift_out_q[DATA_W-1];
  assign spi.cipo_oe  = !ncs_level && ((state_q == DATA) || (state_q == FULL));
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;

  assign spi.cipo_out = 1'b0;
  assign spi.cipo_oe  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Self-checking bench for spi_regfile_periph (NUM_REGS=5, DATA_W=8, ADDR_W=7).
// Honours SPI_READBACK_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_spi_regfile_periph;
  import spi_regfile_pkg::*;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int FLEN     = 16;
  localparam int HALF     = 40;   // SCLK half period: SCLK = clk/8
  localparam int GAP      = 160;  // ncs high for 2 SCLK periods between frames
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_regfile_periph_if spi ();
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [NUM_REGS-1:0]        wr_strobe;
  logic                       frame_err;
  state_t                     dbg_state;

  spi_regfile_periph #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: register contents plus expected pulse events {err, strobe}.
  logic [DATA_W-1:0] model_regs [NUM_REGS];
  logic [5:0]        exp_q[$];
  logic [5:0]        mon_act, mon_exp;

  function automatic logic [NUM_REGS*DATA_W-1:0] model_packed();
    logic [NUM_REGS*DATA_W-1:0] p;
    p = '0;
    for (int k = 0; k < NUM_REGS; k++) p[k*DATA_W +: DATA_W] = model_regs[k];
    return p;
  endfunction

  // Apply one frame's effect by the rules: exact length + write + in range
  // writes; any wrong length or out-of-range write is an error; read is silent.
  task automatic model_frame(input logic [15:0] f, input int nbits);
    int a;
    a = int'(f[14:8]);
    if (nbits == FLEN && f[15] && a < NUM_REGS) begin
      model_regs[a] = f[7:0];
      exp_q.push_back({1'b0, 5'(1 << a)});
    end else if (nbits != FLEN || (f[15] && a >= NUM_REGS)) begin
      exp_q.push_back(6'b100000);
    end
  endtask

  // Scoreboard: every pulse seen must be the next expected one, and a write
  // pulse must coincide with the updated register contents.
  always @(negedge clk) begin
    if (rst_n && (wr_strobe !== '0 || frame_err !== 1'b0)) begin
      mon_act = {frame_err, wr_strobe};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event got=%b expected=none t=%0t", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL event got=%b expected=%b t=%0t", mon_act, mon_exp, $time);
        end
        if (wr_strobe !== '0) begin
          vectors++;
          if (regs_out !== model_packed()) begin
            miscompares++;
            $display("FAIL regs_at_strobe got=%h expected=%h", regs_out, model_packed());
          end
        end
      end
    end
  end

  // Driver: one frame, MSB first; records cipo and cipo_oe just before each rise.
  task automatic spi_xfer(input logic [31:0] bits, input int nbits,
                          output logic [31:0] rd_bits, output logic [31:0] oe_bits);
    rd_bits = '0;
    oe_bits = '0;
    @(negedge clk);
    spi.ncs_in = 1'b0;
    #HALF;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.copi_in = bits[i];
      #HALF;
      rd_bits = {rd_bits[30:0], spi.cipo_out};
      oe_bits = {oe_bits[30:0], spi.cipo_oe};
      spi.sclk_in = 1'b1;
      #HALF;
      spi.sclk_in = 1'b0;
    end
    #HALF;
    spi.ncs_in  = 1'b1;
    spi.copi_in = 1'b0;
  endtask

  // Frame of nbits whose first 16 bits are f (truncated or extended at the tail).
  task automatic do_frame(input logic [15:0] f, input int nbits,
                          output logic [31:0] rd, output logic [31:0] oe);
    logic [31:0] bits;
    if (nbits <= FLEN) bits = {16'h0, f} >> (FLEN - nbits);
    else bits = ({16'h0, f} << (nbits - FLEN)) | 32'($urandom_range(0, (1 << (nbits - FLEN)) - 1));
    spi_xfer(bits, nbits, rd, oe);
    model_frame(f, nbits);
    #GAP;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #30;
    vectors++; if (regs_out !== '0) begin miscompares++; $display("FAIL reset_regs got=%h expected=0", regs_out); end
    vectors++; if (wr_strobe !== '0) begin miscompares++; $display("FAIL reset_strobe got=%b expected=0", wr_strobe); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b expected=0", frame_err); end
    vectors++; if (spi.cipo_out !== 1'b0) begin miscompares++; $display("FAIL reset_cipo got=%b expected=0", spi.cipo_out); end
    vectors++; if (spi.cipo_oe !== 1'b0) begin miscompares++; $display("FAIL reset_cipo_oe got=%b expected=0", spi.cipo_oe); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL reset_state got=%0d expected=%0d", dbg_state, IDLE); end
    vectors++; if (regs_out !== '0) begin miscompares++; $display("FAIL post_reset_regs got=%h expected=0", regs_out); end
  endtask

  task automatic test_write_basic();
    logic [31:0] rd, oe;
    do_frame({1'b1, 7'd3, 8'h42}, FLEN, rd, oe);
    vectors++; if (regs_out[3*DATA_W +: DATA_W] !== 8'h42) begin miscompares++; $display("FAIL write_reg3 got=%h expected=42", regs_out[3*DATA_W +: DATA_W]); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL write_missing_event pending=%0d expected=0", exp_q.size()); end
    vectors++; if (regs_out !== model_packed()) begin miscompares++; $display("FAIL write_regs got=%h expected=%h", regs_out, model_packed()); end
  endtask

  task automatic test_addr_out_of_range();
    logic [31:0] rd, oe;
    do_frame({1'b1, 7'd5, 8'h99}, FLEN, rd, oe);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL oor_missing_event pending=%0d expected=0", exp_q.size()); end
    vectors++; if (regs_out !== model_packed()) begin miscompares++; $display("FAIL oor_regs got=%h expected=%h", regs_out, model_packed()); end
  endtask

  task automatic test_bad_length();
    logic [31:0] rd, oe;
    do_frame({1'b1, 7'd0, 8'hFF}, 15, rd, oe);
    do_frame({1'b1, 7'd0, 8'hFF}, 17, rd, oe);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL badlen_missing_event pending=%0d expected=0", exp_q.size()); end
    vectors++; if (regs_out[DATA_W-1:0] !== 8'h00) begin miscompares++; $display("FAIL badlen_reg0 got=%h expected=00", regs_out[DATA_W-1:0]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd, oe;
    logic [15:0] f;
    do_frame({1'b1, 7'd1, 8'h37}, FLEN, rd, oe);
    f = {1'b1, 7'd1, 8'h5A};
    @(negedge clk);
    spi.ncs_in = 1'b0;
    #HALF;
    for (int i = 15; i >= 7; i--) begin
      spi.copi_in = f[i];
      #HALF;
      spi.sclk_in = 1'b1;
      #HALF;
      spi.sclk_in = 1'b0;
    end
    rst_n = 1'b0;
    spi.ncs_in  = 1'b1;
    spi.copi_in = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = '0;
    #100;
    @(negedge clk);
    rst_n = 1'b1;
    #GAP;
    vectors++; if (regs_out !== '0) begin miscompares++; $display("FAIL abort_regs got=%h expected=0", regs_out); end
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL abort_state got=%0d expected=%0d", dbg_state, IDLE); end
    do_frame(f, FLEN, rd, oe);
    vectors++; if (regs_out[1*DATA_W +: DATA_W] !== 8'h5A) begin miscompares++; $display("FAIL abort_rewrite got=%h expected=5a", regs_out[1*DATA_W +: DATA_W]); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL abort_missing_event pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_readback();
    logic [31:0] rd, oe;
    do_frame({1'b1, 7'd2, 8'hA5}, FLEN, rd, oe);
    do_frame({1'b0, 7'd2, 8'h00}, FLEN, rd, oe);
    vectors++; if (rd[7:0] !== (RB ? 8'hA5 : 8'h00)) begin miscompares++; $display("FAIL read_addr2 got=%b expected=%b", rd[7:0], (RB ? 8'hA5 : 8'h00)); end
    vectors++; if (oe[15:0] !== (RB ? 16'h00FF : 16'h0000)) begin miscompares++; $display("FAIL read_oe got=%h expected=%h", oe[15:0], (RB ? 16'h00FF : 16'h0000)); end
    do_frame({1'b0, 7'd6, 8'h00}, FLEN, rd, oe);
    vectors++; if (rd[7:0] !== 8'h00) begin miscompares++; $display("FAIL read_addr6 got=%h expected=00", rd[7:0]); end
    vectors++; if (spi.cipo_oe !== 1'b0) begin miscompares++; $display("FAIL read_oe_idle got=%b expected=0", spi.cipo_oe); end
    vectors++; if (exp_q.size() != 0 || regs_out !== model_packed()) begin miscompares++; $display("FAIL read_side_effect regs=%h expected=%h pending=%0d", regs_out, model_packed(), exp_q.size()); end
  endtask

  task automatic test_idle_sclk();
    repeat (6) begin
      #HALF; spi.sclk_in = 1'b1; spi.copi_in = 1'b1;
      #HALF; spi.sclk_in = 1'b0;
    end
    spi.copi_in = 1'b0;
    #GAP;
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL idle_sclk_state got=%0d expected=%0d", dbg_state, IDLE); end
    vectors++; if (regs_out !== model_packed()) begin miscompares++; $display("FAIL idle_sclk_regs got=%h expected=%h", regs_out, model_packed()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, oe;
    do_frame({1'b1, 7'd0, 8'h11}, FLEN, rd, oe);
    do_frame({1'b1, 7'd4, 8'h22}, FLEN, rd, oe);
    vectors++; if (regs_out[0 +: DATA_W] !== 8'h11) begin miscompares++; $display("FAIL b2b_reg0 got=%h expected=11", regs_out[0 +: DATA_W]); end
    vectors++; if (regs_out[4*DATA_W +: DATA_W] !== 8'h22) begin miscompares++; $display("FAIL b2b_reg4 got=%h expected=22", regs_out[4*DATA_W +: DATA_W]); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_missing_event pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic [31:0] rd, oe;
    logic [15:0] f;
    logic [7:0]  exp_rd;
    int a, nbits, sel;
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 7);
      f = {1'($urandom_range(0, 1)), 7'(a), 8'($urandom_range(0, 255))};
      sel = $urandom_range(0, 9);
      nbits = (sel < 7) ? FLEN : (sel == 7) ? $urandom_range(0, 15) : $urandom_range(17, 19);
      exp_rd = (RB && a < NUM_REGS) ? model_regs[a] : 8'h00;
      do_frame(f, nbits, rd, oe);
      if (nbits == FLEN && !f[15]) begin
        vectors++;
        if (rd[7:0] !== exp_rd) begin miscompares++; $display("FAIL rand_read n=%0d addr=%0d got=%h expected=%h", n, a, rd[7:0], exp_rd); end
      end
      if (nbits == FLEN) begin
        vectors++;
        if (oe[15:0] !== (RB ? 16'h00FF : 16'h0000)) begin miscompares++; $display("FAIL rand_oe n=%0d got=%h expected=%h", n, oe[15:0], (RB ? 16'h00FF : 16'h0000)); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_missing_event pending=%0d expected=0", exp_q.size()); end
    vectors++; if (regs_out !== model_packed()) begin miscompares++; $display("FAIL rand_regs got=%h expected=%h", regs_out, model_packed()); end
  endtask

  initial begin
    spi.ncs_in  = 1'b1;
    spi.sclk_in = 1'b0;
    spi.copi_in = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = '0;
    test_reset();
    test_write_basic();
    test_addr_out_of_range();
    test_bad_length();
    test_reset_mid_frame();
    test_readback();
    test_idle_sclk();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
